// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for a radix-2 in-place DIT FFT: issues operand and twiddle
// addresses, delays them PIPE_LAT cycles for write-back. Optional stall via FFT_SEQ_STALL_EN.
module fft_stage_sequencer #(
  parameter int LOG2_N   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
`ifdef FFT_SEQ_STALL_EN
  input  logic                      stall_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2(LOG2_N):0]   stage_o,
  output logic                      rd_en_o,
  output logic [LOG2_N-1:0]         rd_addr_a_o,
  output logic [LOG2_N-1:0]         rd_addr_b_o,
  output logic [LOG2_N-2:0]         tw_addr_o,
  output logic                      wr_en_o,
  output logic [LOG2_N-1:0]         wr_addr_a_o,
  output logic [LOG2_N-1:0]         wr_addr_b_o
);

  localparam int AW = LOG2_N;
  localparam int KW = LOG2_N - 1;
  localparam int SW = $clog2(LOG2_N) + 1;
  localparam int DW = $clog2(PIPE_LAT) + 1;

  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_t;

  state_t        state, state_n;
  logic [SW-1:0] stage, stage_n;
  logic [KW-1:0] k, k_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          stall;
  logic          hold;

  logic [AW-1:0] rd_a, rd_b;
  logic [KW-1:0] rd_tw;
  wb_t           pipe [PIPE_LAT];

`ifdef FFT_SEQ_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Stall never blocks acceptance of a start in IDLE.
  assign hold = stall && (state != IDLE);

  // Upper operand: insert a zero at bit s of k; lower operand sets that bit.
  function automatic logic [AW-1:0] calc_a(input logic [SW-1:0] s, input logic [KW-1:0] kk);
    int            sh;
    logic [AW-1:0] kx;
    logic [AW-1:0] half_m1;
    sh      = int'(s);
    kx      = AW'(kk);
    half_m1 = (AW'(1) << sh) - AW'(1);
    return ((kx >> sh) << (sh + 1)) | (kx & half_m1);
  endfunction

  function automatic logic [KW-1:0] calc_tw(input logic [SW-1:0] s, input logic [KW-1:0] kk);
    int            sh;
    logic [AW-1:0] jx;
    sh = int'(s);
    jx = AW'(kk) & ((AW'(1) << sh) - AW'(1));
    return KW'(jx << (LOG2_N - 1 - sh));
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      stage <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      k     <= k_n;
      dcnt  <= dcnt_n;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    stage_n = stage;
    k_n     = k;
    dcnt_n  = dcnt;
    if (!hold) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_n = RUN;
            stage_n = '0;
            k_n     = '0;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            state_n = DRAIN;
            dcnt_n  = '0;
          end else begin
            k_n = k + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            if (stage == S_LAST) begin
              state_n = DONE;
            end else begin
              state_n = RUN;
              stage_n = stage + 1'b1;
              k_n     = '0;
            end
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Read addresses are registered from the next-state counters so they line up
  // with RUN in the same cycle and hold their value outside RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_a  <= '0;
      rd_b  <= '0;
      rd_tw <= '0;
    end else if (!hold && state_n == RUN) begin
      rd_a  <= calc_a(stage_n, k_n);
      rd_b  <= calc_a(stage_n, k_n) | (AW'(1) << stage_n);
      rd_tw <= calc_tw(stage_n, k_n);
    end
  end

  // NOTE: the write-back pipe is reset explicitly so an abort discards every
  // in-flight write instead of replaying stale entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else if (!hold) begin
      pipe[0] <= '{valid: (state == RUN), a: rd_a, b: rd_b};
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign busy_o      = (state == RUN) || (state == DRAIN);
  assign done_o      = (state == DONE) && !stall;
  assign stage_o     = stage;
  assign rd_en_o     = (state == RUN) && !stall;
  assign rd_addr_a_o = rd_a;
  assign rd_addr_b_o = rd_b;
  assign tw_addr_o   = rd_tw;
  assign wr_en_o     = pipe[PIPE_LAT-1].valid && !stall;
  assign wr_addr_a_o = pipe[PIPE_LAT-1].a;
  assign wr_addr_b_o = pipe[PIPE_LAT-1].b;

endmodule
